keypad_decoder: RTL

Scans a 5-row × 4-column calculator key matrix, debounces it, and turns each accepted key press into a single-cycle event for the calculation stage. Outputs are `newhex`/`hexcode`, `newop`/`opcode` and `eq`. The block sits directly upstream of the calculator core. It is the only block that touches the physical key matrix.

---
 rtl/keypad_pkg.sv | 57 +++++
 rtl/keypad_decoder_if.sv | 13 +
 rtl/keypad_row_scanner.sv | 79 +++++++
 rtl/keypad_decoder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad constants, key/opcode encodings and the debounce state type.
// Also holds the helpers that map a scanned frame to a single key index.
package keypad_pkg;

   localparam int NUM_ROWS = 5;
   localparam int NUM_COLS = 4;
   localparam int NUM_KEYS = 20;
   localparam int KEY_W    = 5;

   typedef logic [KEY_W-1:0] key_t;

   localparam key_t KEY_ADD  = 5'd16;
   localparam key_t KEY_MUL  = 5'd17;
   localparam key_t KEY_SUB  = 5'd18;
   localparam key_t KEY_EQ   = 5'd19;
   localparam key_t KEY_NONE = 5'd31;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_MUL = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_HELD,
      ST_RELEASE_WAIT
   } deb_state_t;

   // A frame yields a key only when exactly one switch is closed; chords read as NONE.
   function automatic key_t frame_to_key(input logic [NUM_KEYS-1:0] frame);
      key_t key;
      int   hits;
      key  = KEY_NONE;
      hits = 0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (frame[i]) begin
            hits++;
            key = key_t'(i);
         end
      end
      if (hits != 1) begin
         key = KEY_NONE;
      end
      return key;
   endfunction

   function automatic logic [1:0] key_to_op(input key_t key);
      logic [1:0] op;
      case (key)
         KEY_MUL: op = OP_MUL;
         KEY_SUB: op = OP_SUB;
         default: op = OP_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/keypad_decoder_if.sv
// Event bus from the keypad decoder to the calculator core.
interface keypad_decoder_if;

   logic       newhex;
   logic [3:0] hexcode;
   logic       newop;
   logic [1:0] opcode;
   logic       eq;

   modport master (output newhex, hexcode, newop, opcode, eq);
   modport slave  (input  newhex, hexcode, newop, opcode, eq);

endinterface

// File: rtl/keypad_row_scanner.sv
// Drives the key matrix one row at a time and assembles the synchronized
// column samples into a 20-bit frame, strobing frame_done on the last row.
module keypad_row_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_COLS-1:0] col_n,
   output logic [NUM_ROWS-1:0] row_n,
   output logic [NUM_KEYS-1:0] frame,
   output logic                frame_done
);

   localparam int                SLOT_W    = $clog2(SCAN_DIV);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam int                ROW_W     = $clog2(NUM_ROWS);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_ROWS - 1);

   logic [NUM_COLS-1:0] col_meta_reg;
   logic [NUM_COLS-1:0] col_sync_reg;
   logic [SLOT_W-1:0]   slot_cnt_reg;
   logic [ROW_W-1:0]    row_idx_reg;
   logic [NUM_ROWS-1:0] row_n_reg;
   logic                slot_end;

   // Columns idle high through the pull-ups, so the synchronizer resets to "no key".
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_meta_reg <= '1;
         col_sync_reg <= '1;
      end else begin
         col_meta_reg <= col_n;
         col_sync_reg <= col_meta_reg;
      end
   end

   assign slot_end = (slot_cnt_reg == SLOT_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         slot_cnt_reg <= '0;
         row_idx_reg  <= '0;
         row_n_reg    <= 5'b11110;
      end else if (slot_end) begin
         slot_cnt_reg <= '0;
         row_idx_reg  <= (row_idx_reg == ROW_LAST) ? '0 : row_idx_reg + 1'b1;
         row_n_reg    <= {row_n_reg[NUM_ROWS-2:0], row_n_reg[NUM_ROWS-1]};
      end else begin
         slot_cnt_reg <= slot_cnt_reg + 1'b1;
      end
   end

   // During a row's sampling cycle its slice is forwarded live, so the frame
   // is complete in the same cycle frame_done strobes.
   generate
      for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
         logic [NUM_COLS-1:0] bits_reg;
         logic                row_sample;

         assign row_sample = slot_end && (row_idx_reg == ROW_W'(gi));

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               bits_reg <= '0;
            end else if (row_sample) begin
               bits_reg <= ~col_sync_reg;
            end
         end

         assign frame[gi*NUM_COLS +: NUM_COLS] = row_sample ? ~col_sync_reg : bits_reg;
      end
   endgenerate

   assign row_n      = row_n_reg;
   assign frame_done = slot_end && (row_idx_reg == ROW_LAST);

endmodule

// File: rtl/keypad_decoder.sv
// Calculator keypad front end: scans and debounces the matrix and emits one
// single-cycle hex/operator/equals event per accepted press.
module keypad_decoder
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 3
) (
   input  logic                clock,
   input  logic                reset,
   output logic [NUM_ROWS-1:0] row_n,
   input  logic [NUM_COLS-1:0] col_n,
   keypad_decoder_if.master    ev
);

   localparam int               CNT_W   = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [NUM_KEYS-1:0] frame;
   logic                frame_done;
   key_t                frame_key;

   deb_state_t       state_reg, state_next;
   key_t             cand_reg, cand_next;
   logic [CNT_W-1:0] stable_cnt_reg, stable_cnt_next;
   logic [CNT_W-1:0] cnt_inc;
   logic             emit;

   logic       newhex_reg;
   logic [3:0] hexcode_reg;
   logic       newop_reg;
   logic [1:0] opcode_reg;
   logic       eq_reg;

   keypad_row_scanner #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scanner (
      .clock      (clock),
      .reset      (reset),
      .col_n      (col_n),
      .row_n      (row_n),
      .frame      (frame),
      .frame_done (frame_done)
   );

   assign frame_key = frame_to_key(frame);
   assign cnt_inc   = (stable_cnt_reg == CNT_MAX) ? CNT_MAX : stable_cnt_reg + CNT_ONE;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg      <= ST_IDLE;
         cand_reg       <= KEY_NONE;
         stable_cnt_reg <= '0;
      end else begin
         state_reg      <= state_next;
         cand_reg       <= cand_next;
         stable_cnt_reg <= stable_cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cand_next       = cand_reg;
      stable_cnt_next = stable_cnt_reg;
      emit            = 1'b0;
      if (frame_done) begin
         case (state_reg)
            ST_IDLE: begin
               if (frame_key != KEY_NONE) begin
                  cand_next       = frame_key;
                  stable_cnt_next = CNT_ONE;
                  if (CNT_ONE >= CNT_MAX) begin
                     state_next = ST_HELD;
                     emit       = 1'b1;
                  end else begin
                     state_next = ST_PRESS_WAIT;
                  end
               end
            end
            ST_PRESS_WAIT: begin
               if (frame_key == cand_reg) begin
                  stable_cnt_next = cnt_inc;
                  if (cnt_inc == CNT_MAX) begin
                     state_next = ST_HELD;
                     emit       = 1'b1;
                  end
               end else if (frame_key == KEY_NONE) begin
                  state_next      = ST_IDLE;
                  stable_cnt_next = '0;
               end else begin
                  cand_next       = frame_key;
                  stable_cnt_next = CNT_ONE;
               end
            end
            ST_HELD: begin
               if (frame_key != cand_reg) begin
                  state_next      = ST_RELEASE_WAIT;
                  stable_cnt_next = CNT_ONE;
               end
            end
            ST_RELEASE_WAIT: begin
               // Sliding onto another key restarts the release count; a new key
               // is only taken after a clean release.
               if (frame_key == KEY_NONE) begin
                  stable_cnt_next = cnt_inc;
                  if (cnt_inc == CNT_MAX) begin
                     state_next      = ST_IDLE;
                     stable_cnt_next = '0;
                  end
               end else if (frame_key == cand_reg) begin
                  state_next      = ST_HELD;
                  stable_cnt_next = '0;
               end else begin
                  stable_cnt_next = '0;
               end
            end
            default: begin
               state_next      = ST_IDLE;
               stable_cnt_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         newhex_reg  <= 1'b0;
         hexcode_reg <= '0;
         newop_reg   <= 1'b0;
         opcode_reg  <= OP_ADD;
         eq_reg      <= 1'b0;
      end else begin
         newhex_reg <= 1'b0;
         newop_reg  <= 1'b0;
         eq_reg     <= 1'b0;
         if (emit) begin
            if (cand_next < KEY_ADD) begin
               newhex_reg  <= 1'b1;
               hexcode_reg <= cand_next[3:0];
            end else if (cand_next == KEY_EQ) begin
               eq_reg <= 1'b1;
            end else begin
               newop_reg  <= 1'b1;
               opcode_reg <= key_to_op(cand_next);
            end
         end
      end
   end

   assign ev.newhex  = newhex_reg;
   assign ev.hexcode = hexcode_reg;
   assign ev.newop   = newop_reg;
   assign ev.opcode  = opcode_reg;
   assign ev.eq      = eq_reg;

endmodule
